// File: rtl/memwrite_checker_pkg.sv
// memchk_pkg: types and constants shared by the memwrite_checker block.
//   state_e    - checker FSM states (idle, running, verdict pass/fail)
//   FC_*       - fail cause codes reported on fail_code
//   idx_width  - table index width, kept at least 1 bit for single-entry tables
package memchk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_BAD_ADDR = 2'd1;
    localparam logic [1:0] FC_BAD_DATA = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memwrite_checker_if.sv
// memwrite_checker_if: bundles the observed store bus, the expectation-table
// programming port and the verdict/status outputs of memwrite_checker.
//   master : drives start, store bus and cfg_*; reads status
//   slave  : the checker side
interface memwrite_checker_if
    import memchk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int N_EXP  = 4,
    parameter int CYC_W  = 32
);
    localparam int IDX_W = idx_width(N_EXP);
    localparam int CNT_W = $clog2(N_EXP + 1);

    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [CNT_W-1:0]  cfg_count;
    logic              cfg_ign_en;
    logic [ADDR_W-1:0] cfg_ign_addr;

    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        fail_code;
    logic [CNT_W-1:0]  match_idx;
    logic [CYC_W-1:0]  cycle_count;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    modport master (
        output start, memwrite, dataadr, writedata,
        output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, cfg_ign_en, cfg_ign_addr,
        input  busy, done, pass, fail_code, match_idx, cycle_count, fail_addr, fail_data
    );

    modport slave (
        input  start, memwrite, dataadr, writedata,
        input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, cfg_ign_en, cfg_ign_addr,
        output busy, done, pass, fail_code, match_idx, cycle_count, fail_addr, fail_data
    );

endinterface

// File: rtl/memwrite_checker_table.sv
// memchk_table: N_EXP-entry register file of expected (address, data) pairs.
//   clk, reset  : clock, async active-high reset (clears every entry)
//   we_i        : write strobe; wr_idx_i >= N_EXP is dropped
//   wr_*        : write index / address / data
//   rd_idx_i    : read index (may equal N_EXP once a run is complete -> reads 0)
//   rd_*_o      : combinational read of the selected entry
module memchk_table
    import memchk_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int N_EXP  = 4,
    parameter int IDX_W  = idx_width(N_EXP),
    parameter int CNT_W  = $clog2(N_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [ADDR_W-1:0] addr_q [N_EXP];
    logic [DATA_W-1:0] data_q [N_EXP];

    // Table storage: cleared on reset, one entry written per enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_EXP; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (we_i && (int'(wr_idx_i) < N_EXP)) begin
            addr_q[wr_idx_i] <= wr_addr_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read mux; out-of-range index yields zero rather than aliasing an entry.
    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        for (int i = 0; i < N_EXP; i++) begin
            rd_addr_o = (int'(rd_idx_i) == i) ? addr_q[i] : rd_addr_o;
            rd_data_o = (int'(rd_idx_i) == i) ? data_q[i] : rd_data_o;
        end
    end

endmodule

// File: rtl/memwrite_checker.sv
// memwrite_checker: matches the core's store stream, in order, against a
// programmable table of expected (address, data) pairs, tolerating one
// optional scratch address and enforcing a RUN-cycle timeout.
//   clk, reset : clock, async active-high reset
//   bus        : memwrite_checker_if.slave (store bus, cfg port, status)
module memwrite_checker
    import memchk_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int N_EXP   = 4,
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 1000
) (
    input logic                clk,
    input logic                reset,
    memwrite_checker_if.slave  bus
);
    localparam int IDX_W = idx_width(N_EXP);
    localparam int CNT_W = $clog2(N_EXP + 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(N_EXP);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [1:0]        fc_q, fc_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ign_en_q, ign_en_d;
    logic [ADDR_W-1:0] ign_addr_q, ign_addr_d;
    logic              busy_q, done_q, pass_q;

    logic [ADDR_W-1:0] exp_addr_s;
    logic [DATA_W-1:0] exp_data_s;
    logic              tbl_we_s, addr_hit_s, data_hit_s, ign_hit_s;

    // The table is frozen while a run is in progress.
    assign tbl_we_s   = bus.cfg_we && (state_q != ST_RUN);
    assign addr_hit_s = (bus.dataadr == exp_addr_s);
    assign data_hit_s = (bus.writedata == exp_data_s);
    assign ign_hit_s  = ign_en_q && (bus.dataadr == ign_addr_q);

    memchk_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_EXP  (N_EXP),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .we_i      (tbl_we_s),
        .wr_idx_i  (bus.cfg_idx),
        .wr_addr_i (bus.cfg_addr),
        .wr_data_i (bus.cfg_data),
        .rd_idx_i  (match_q),
        .rd_addr_o (exp_addr_s),
        .rd_data_o (exp_data_s)
    );

    // Next-state logic: run start/latch, in-order write matching, timeout.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        cycle_d    = cycle_q;
        fc_d       = fc_q;
        fa_d       = fa_q;
        fd_d       = fd_q;
        count_d    = count_q;
        ign_en_d   = ign_en_q;
        ign_addr_d = ign_addr_q;
        case (state_q)
            ST_RUN: begin
                if (cycle_q != {CYC_W{1'b1}}) begin
                    cycle_d = cycle_q + CYC_W'(1);
                end else begin
                    cycle_d = cycle_q;
                end
                if (count_q == '0) begin
                    state_d = ST_PASS;
                end else if (bus.memwrite && addr_hit_s && data_hit_s) begin
                    match_d = match_q + CNT_W'(1);
                    state_d = (match_d == count_q) ? ST_PASS : ST_RUN;
                end else if (bus.memwrite && addr_hit_s) begin
                    state_d = ST_FAIL;
                    fc_d    = FC_BAD_DATA;
                    fa_d    = bus.dataadr;
                    fd_d    = bus.writedata;
                end else if (bus.memwrite && !ign_hit_s) begin
                    state_d = ST_FAIL;
                    fc_d    = FC_BAD_ADDR;
                    fa_d    = bus.dataadr;
                    fd_d    = bus.writedata;
                end else begin
                    state_d = ST_RUN;
                end
                // Last allowed cycle: anything short of a completing match times out.
                if ((cycle_q == LAST_CYC) && (state_d != ST_PASS)) begin
                    state_d = ST_FAIL;
                    fc_d    = FC_TIMEOUT;
                    fa_d    = '0;
                    fd_d    = '0;
                end else begin
                    fc_d = fc_d;
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    match_d    = '0;
                    cycle_d    = '0;
                    fc_d       = FC_NONE;
                    fa_d       = '0;
                    fd_d       = '0;
                    count_d    = (bus.cfg_count > MAX_CNT) ? MAX_CNT : bus.cfg_count;
                    ign_en_d   = bus.cfg_ign_en;
                    ign_addr_d = bus.cfg_ign_addr;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched config and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            match_q    <= '0;
            cycle_q    <= '0;
            fc_q       <= FC_NONE;
            fa_q       <= '0;
            fd_q       <= '0;
            count_q    <= '0;
            ign_en_q   <= 1'b0;
            ign_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            cycle_q    <= cycle_d;
            fc_q       <= fc_d;
            fa_q       <= fa_d;
            fd_q       <= fd_d;
            count_q    <= count_d;
            ign_en_q   <= ign_en_d;
            ign_addr_q <= ign_addr_d;
            busy_q     <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_PASS) || (state_d == ST_FAIL);
            pass_q     <= (state_d == ST_PASS);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail_code   = fc_q;
    assign bus.match_idx   = match_q;
    assign bus.cycle_count = cycle_q;
    assign bus.fail_addr   = fa_q;
    assign bus.fail_data   = fd_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// tb_memwrite_checker: scoreboard bench for memwrite_checker. Each run's
// expected verdict is queued as its stimulus is driven and popped when the
// DUT raises done.
module tb_memwrite_checker;
    import memchk_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int N_EXP   = 4;
    localparam int CYC_W   = 32;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = $clog2(N_EXP + 1);
    localparam int IDX_W   = idx_width(N_EXP);

    typedef struct {
        int               id;
        logic             pass;
        logic [1:0]       fc;
        logic [CNT_W-1:0] mi;
        logic [15:0]      fa;
        logic [15:0]      fd;
        logic             chk_cyc;
        logic [31:0]      cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    int   next_id = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    memwrite_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_EXP(N_EXP), .CYC_W(CYC_W)) bus ();

    memwrite_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_EXP(N_EXP), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_entry(input int idx, input logic [15:0] a, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = IDX_W'(idx);
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_run(input int cnt, input logic ign_en, input logic [15:0] ign_a);
        bus.cfg_count    = CNT_W'(cnt);
        bus.cfg_ign_en   = ign_en;
        bus.cfg_ign_addr = ign_a;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        tick();
        bus.memwrite  = 1'b0;
    endtask

    task automatic expect_run(input logic p, input logic [1:0] fc, input int mi,
                              input int fa, input int fd, input logic cc, input int cyc);
        exp_t e;
        e.id = next_id;
        next_id++;
        e.pass = p;
        e.fc = fc;
        e.mi = CNT_W'(mi);
        e.fa = 16'(fa);
        e.fd = 16'(fd);
        e.chk_cyc = cc;
        e.cyc = 32'(cyc);
        sb_q.push_back(e);
    endtask

    task automatic wait_verdict();
        exp_t e;
        int n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        check_val($sformatf("r%0d.done", e.id), 64'(bus.done), 64'(1));
        check_val($sformatf("r%0d.busy", e.id), 64'(bus.busy), 64'(0));
        check_val($sformatf("r%0d.pass", e.id), 64'(bus.pass), 64'(e.pass));
        check_val($sformatf("r%0d.fail_code", e.id), 64'(bus.fail_code), 64'(e.fc));
        check_val($sformatf("r%0d.match_idx", e.id), 64'(bus.match_idx), 64'(e.mi));
        check_val($sformatf("r%0d.fail_addr", e.id), 64'(bus.fail_addr), 64'(e.fa));
        check_val($sformatf("r%0d.fail_data", e.id), 64'(bus.fail_data), 64'(e.fd));
        if (e.chk_cyc) begin
            check_val($sformatf("r%0d.cycle_count", e.id), 64'(bus.cycle_count), 64'(e.cyc));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".busy"}, 64'(bus.busy), 64'(0));
        check_val({tag, ".done"}, 64'(bus.done), 64'(0));
        check_val({tag, ".pass"}, 64'(bus.pass), 64'(0));
        check_val({tag, ".fail_code"}, 64'(bus.fail_code), 64'(0));
        check_val({tag, ".match_idx"}, 64'(bus.match_idx), 64'(0));
        check_val({tag, ".cycle_count"}, 64'(bus.cycle_count), 64'(0));
        check_val({tag, ".fail_addr"}, 64'(bus.fail_addr), 64'(0));
        check_val({tag, ".fail_data"}, 64'(bus.fail_data), 64'(0));
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.memwrite     = 1'b0;
        bus.dataadr      = '0;
        bus.writedata    = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_idx      = '0;
        bus.cfg_addr     = '0;
        bus.cfg_data     = '0;
        bus.cfg_count    = '0;
        bus.cfg_ign_en   = 1'b0;
        bus.cfg_ign_addr = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Ignored scratch write then the expected one.
        cfg_entry(0, 16'd84, 16'd7);
        expect_run(1'b1, FC_NONE, 1, 0, 0, 1'b1, 2);
        start_run(1, 1'b1, 16'd80);
        check_val("t1.busy_after_start", 64'(bus.busy), 64'(1));
        wr(16'd80, 16'd5);
        check_val("t1.busy_after_ign", 64'(bus.busy), 64'(1));
        wr(16'd84, 16'd7);
        wait_verdict();

        // Right address, wrong data.
        expect_run(1'b0, FC_BAD_DATA, 0, 84, 6, 1'b0, 0);
        start_run(1, 1'b0, 16'd0);
        wr(16'd84, 16'd6);
        wait_verdict();

        // Scratch address with ignore disabled.
        expect_run(1'b0, FC_BAD_ADDR, 0, 80, 5, 1'b0, 0);
        start_run(1, 1'b0, 16'd80);
        wr(16'd80, 16'd5);
        wait_verdict();

        // No writes: timeout after TIMEOUT RUN cycles.
        expect_run(1'b0, FC_TIMEOUT, 0, 0, 0, 1'b1, TIMEOUT);
        start_run(1, 1'b0, 16'd0);
        wait_verdict();

        // Completing write on the last allowed cycle wins over timeout.
        expect_run(1'b1, FC_NONE, 1, 0, 0, 1'b1, TIMEOUT);
        start_run(1, 1'b0, 16'd0);
        repeat (TIMEOUT - 1) tick();
        check_val("t4b.busy_before_last", 64'(bus.busy), 64'(1));
        wr(16'd84, 16'd7);
        wait_verdict();

        // Three entries in order; cfg_we and start during RUN must be ignored.
        cfg_entry(0, 16'h0010, 16'd1);
        cfg_entry(1, 16'h0014, 16'd2);
        cfg_entry(2, 16'h0018, 16'd3);
        expect_run(1'b1, FC_NONE, 3, 0, 0, 1'b1, 3);
        start_run(3, 1'b0, 16'd0);
        wr(16'h0010, 16'd1);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = IDX_W'(0);
        bus.cfg_addr = 16'h0099;
        bus.cfg_data = 16'h0099;
        bus.start    = 1'b1;
        wr(16'h0014, 16'd2);
        bus.cfg_we   = 1'b0;
        bus.start    = 1'b0;
        wr(16'h0018, 16'd3);
        wait_verdict();

        // Reordered writes.
        expect_run(1'b0, FC_BAD_ADDR, 0, 'h14, 2, 1'b0, 0);
        start_run(3, 1'b0, 16'd0);
        wr(16'h0014, 16'd2);
        wait_verdict();

        // Table must still hold the original entry 0.
        expect_run(1'b1, FC_NONE, 3, 0, 0, 1'b0, 0);
        start_run(3, 1'b0, 16'd0);
        wr(16'h0010, 16'd1);
        wr(16'h0014, 16'd2);
        wr(16'h0018, 16'd3);
        wait_verdict();

        // Count above N_EXP clamps to N_EXP.
        for (int i = 0; i < N_EXP; i++) cfg_entry(i, 16'(16'h0020 + 4 * i), 16'(10 + i));
        expect_run(1'b1, FC_NONE, N_EXP, 0, 0, 1'b0, 0);
        start_run(7, 1'b0, 16'd0);
        for (int i = 0; i < N_EXP; i++) wr(16'(16'h0020 + 4 * i), 16'(10 + i));
        wait_verdict();

        // Reset mid-RUN after one match.
        start_run(3, 1'b0, 16'd0);
        wr(16'h0020, 16'd10);
        check_val("rst.match_before", 64'(bus.match_idx), 64'(1));
        reset = 1'b1;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        tick();

        // Table was cleared: entry 0 now expects address 0.
        expect_run(1'b0, FC_BAD_ADDR, 0, 'h20, 10, 1'b0, 0);
        start_run(1, 1'b0, 16'd0);
        wr(16'h0020, 16'd10);
        wait_verdict();

        // Count 0 passes one cycle after busy.
        cfg_entry(0, 16'd84, 16'd7);
        expect_run(1'b1, FC_NONE, 0, 0, 0, 1'b0, 0);
        start_run(0, 1'b0, 16'd0);
        check_val("cnt0.busy", 64'(bus.busy), 64'(1));
        check_val("cnt0.pass_early", 64'(bus.pass), 64'(0));
        tick();
        check_val("cnt0.pass_next", 64'(bus.pass), 64'(1));
        wait_verdict();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
